// File: rtl/core_pkg.sv
// core_pkg: shared core constants and MEM-stage FSM state encoding
package core_pkg;
  localparam int XLEN = 32;
  localparam int PC_INC = 4;
  typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: combinational branch/jump taken decision and redirect target
module branch_resolve #(
  parameter int XLEN = 32
) (
  input  logic            branch,
  input  logic            zero,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_imm,
  output logic            taken,
  output logic [XLEN-1:0] target
);
  // jalr targets are forced to an even address by clearing bit 0
  always_comb begin
    taken = (branch & zero) | jal | jalr;
    target = jalr ? (alu_result & ~XLEN'(1)) : pc_imm;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage with dmem handshake, redirect resolution and MEM/WB register
module mem_access_stage #(
  parameter int XLEN = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Ctl_MemtoReg_in,
  input  logic            Ctl_RegWrite_in,
  input  logic            Ctl_MemRead_in,
  input  logic            Ctl_MemWrite_in,
  input  logic            Ctl_Branch_in,
  input  logic            Zero_in,
  input  logic            jal_in,
  input  logic            jalr_in,
  input  logic [4:0]      Rd_in,
  input  logic [XLEN-1:0] ALUresult_in,
  input  logic [XLEN-1:0] PCimm_in,
  input  logic [XLEN-1:0] ReadData2_in,
  input  logic [XLEN-1:0] PC_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic            stall,
  output logic            flush,
  output logic            PCSrc,
  output logic [XLEN-1:0] PCtarget,
  output logic [XLEN-1:0] mem_fwd_data,
  output logic            mem_err,
  output logic            Ctl_MemtoReg_out,
  output logic            Ctl_RegWrite_out,
  output logic [4:0]      Rd_out,
  output logic [XLEN-1:0] ReadData_out,
  output logic [XLEN-1:0] ALUresult_out
);
  import core_pkg::*;
  state_t state;
  logic [3:0] cnt;
  logic mem_op, load, timeout_now, taken;
  // a simultaneous read+write is a store; ready in the last wait cycle still wins over timeout
  always_comb begin
    mem_op = Ctl_MemRead_in | Ctl_MemWrite_in;
    load = Ctl_MemRead_in & ~Ctl_MemWrite_in;
    timeout_now = (state == WAIT) & mem_op & ~dmem_ready & (cnt == 4'(WAIT_MAX - 1));
    stall = mem_op & ~dmem_ready & ~timeout_now;
    dmem_req = mem_op & ~timeout_now;
    dmem_we = Ctl_MemWrite_in;
    dmem_addr = ALUresult_in;
    dmem_wdata = ReadData2_in;
    mem_fwd_data = ALUresult_in;
    PCSrc = taken;
    flush = taken;
  end
  branch_resolve #(.XLEN(XLEN)) u_branch_resolve (
    .branch(Ctl_Branch_in),
    .zero(Zero_in),
    .jal(jal_in),
    .jalr(jalr_in),
    .alu_result(ALUresult_in),
    .pc_imm(PCimm_in),
    .taken(taken),
    .target(PCtarget)
  );
  // access FSM, sticky timeout flag and MEM/WB register; stalled cycles write a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      mem_err <= 1'b0;
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      Rd_out <= '0;
      ReadData_out <= '0;
      ALUresult_out <= '0;
    end else begin
      state <= stall ? WAIT : IDLE;
      cnt <= (state == WAIT && stall) ? cnt + 4'd1 : '0;
      mem_err <= mem_err | timeout_now;
      Ctl_MemtoReg_out <= Ctl_MemtoReg_in & ~stall;
      Ctl_RegWrite_out <= Ctl_RegWrite_in & ~stall;
      if (!stall) begin
        Rd_out <= Rd_in;
        ReadData_out <= (load & dmem_ready) ? dmem_rdata : '0;
        ALUresult_out <= (jal_in | jalr_in) ? PC_in + XLEN'(PC_INC) : ALUresult_in;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table-driven and sequence checks for mem_access_stage
module tb_mem_access_stage;
  logic clk = 0, reset;
  logic mtr, rw, mr, mw, br, zero, jal, jalr;
  logic [4:0] rd;
  logic [31:0] alu, pcimm, rd2, pc, rdata;
  logic rdy;
  logic req, we, stall, flush, pcsrc, mem_err, mtr_o, rw_o;
  logic [31:0] addr, wdata, tgt, fwd, rdata_o, alu_o;
  logic [4:0] rd_o;
  int checks = 0, failures = 0;

  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .Ctl_MemtoReg_in(mtr), .Ctl_RegWrite_in(rw), .Ctl_MemRead_in(mr), .Ctl_MemWrite_in(mw),
    .Ctl_Branch_in(br), .Zero_in(zero), .jal_in(jal), .jalr_in(jalr), .Rd_in(rd),
    .ALUresult_in(alu), .PCimm_in(pcimm), .ReadData2_in(rd2), .PC_in(pc),
    .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_wdata(wdata),
    .dmem_rdata(rdata), .dmem_ready(rdy), .stall(stall), .flush(flush), .PCSrc(pcsrc),
    .PCtarget(tgt), .mem_fwd_data(fwd), .mem_err(mem_err),
    .Ctl_MemtoReg_out(mtr_o), .Ctl_RegWrite_out(rw_o), .Rd_out(rd_o),
    .ReadData_out(rdata_o), .ALUresult_out(alu_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mr, mw, br, z, jal, jalr, rw, mtr;
    logic [4:0] rd;
    logic [31:0] alu, pcimm, rd2, pc;
    logic rdy;
    logic [31:0] rdata;
    logic pcsrc;
    logic [31:0] tgt;
    logic req, we;
    logic [31:0] alu_o, rd_o;
    logic rw_o;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    mr = v.mr; mw = v.mw; br = v.br; zero = v.z; jal = v.jal; jalr = v.jalr;
    rw = v.rw; mtr = v.mtr; rd = v.rd; alu = v.alu; pcimm = v.pcimm; rd2 = v.rd2;
    pc = v.pc; rdy = v.rdy; rdata = v.rdata;
  endtask

  task automatic clear_in();
    {mr, mw, br, zero, jal, jalr, rw, mtr, rdy} = '0;
    rd = '0; alu = '0; pcimm = '0; rd2 = '0; pc = '0; rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1,0,0,0,0,0,1,1, 5, 32'h100, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 1, 0, 32'h100, 32'hDEADBEEF, 1};
    vecs[1] = '{0,1,0,0,0,0,0,0, 0, 32'h40, 0, 32'h1234, 4, 1, 32'h11, 0, 0, 1, 1, 32'h40, 0, 0};
    vecs[2] = '{0,0,1,1,0,0,0,0, 0, 0, 32'h80, 0, 8, 0, 0, 1, 32'h80, 0, 0, 0, 0, 0};
    vecs[3] = '{0,0,1,0,0,0,0,0, 0, 7, 32'h80, 0, 8, 0, 0, 0, 32'h80, 0, 0, 7, 0, 0};
    vecs[4] = '{0,0,0,0,0,1,1,0, 1, 32'h203, 32'h999, 0, 32'h10, 0, 0, 1, 32'h202, 0, 0, 32'h14, 0, 1};
    vecs[5] = '{0,0,0,0,1,0,1,0, 1, 7, 32'h400, 0, 32'hFFFFFFFC, 0, 0, 1, 32'h400, 0, 0, 0, 0, 1};
    vecs[6] = '{0,0,0,0,0,0,1,0, 9, 32'h55, 32'h30, 32'h77, 32'h20, 0, 0, 0, 32'h30, 0, 0, 32'h55, 0, 1};
    vecs[7] = '{1,1,0,0,0,0,0,0, 0, 32'h44, 0, 32'hAB, 0, 1, 32'hCAFE, 0, 0, 1, 1, 32'h44, 0, 0};
    vecs[8] = '{0,0,0,0,0,0,1,0, 3, 32'h12, 0, 0, 0, 1, 32'hBEEF, 0, 0, 0, 0, 32'h12, 0, 1};

    clear_in();
    reset = 1;
    tick(); tick();
    chk("rst_rw", 32'(rw_o), 0);
    chk("rst_mtr", 32'(mtr_o), 0);
    chk("rst_rd", 32'(rd_o), 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_alu", alu_o, 0);
    chk("rst_err", 32'(mem_err), 0);
    chk("rst_req", 32'(req), 0);
    reset = 0;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 0);
      chk($sformatf("v%0d_pcsrc", i), 32'(pcsrc), 32'(vecs[i].pcsrc));
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].pcsrc));
      chk($sformatf("v%0d_tgt", i), tgt, vecs[i].tgt);
      chk($sformatf("v%0d_req", i), 32'(req), 32'(vecs[i].req));
      chk($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].we));
      chk($sformatf("v%0d_addr", i), addr, vecs[i].alu);
      chk($sformatf("v%0d_wdata", i), wdata, vecs[i].rd2);
      chk($sformatf("v%0d_fwd", i), fwd, vecs[i].alu);
      tick();
      chk($sformatf("v%0d_alu_o", i), alu_o, vecs[i].alu_o);
      chk($sformatf("v%0d_rdata_o", i), rdata_o, vecs[i].rd_o);
      chk($sformatf("v%0d_rw_o", i), 32'(rw_o), 32'(vecs[i].rw_o));
      chk($sformatf("v%0d_mtr_o", i), 32'(mtr_o), 32'(vecs[i].mtr));
      chk($sformatf("v%0d_rd_o", i), 32'(rd_o), 32'(vecs[i].rd));
    end

    clear_in();
    rw = 1; rd = 4; alu = 32'h77;
    tick();
    clear_in();
    mw = 1; alu = 32'h40; rd2 = 32'h1234;
    #1;
    chk("st_stall1", 32'(stall), 1);
    chk("st_req1", 32'(req), 1);
    chk("st_we1", 32'(we), 1);
    chk("st_prev_rw", 32'(rw_o), 1);
    tick();
    chk("st_stall2", 32'(stall), 1);
    chk("st_we2", 32'(we), 1);
    chk("st_addr2", addr, 32'h40);
    chk("st_wdata2", wdata, 32'h1234);
    chk("st_bubble_rw", 32'(rw_o), 0);
    chk("st_hold_alu", alu_o, 32'h77);
    chk("st_hold_rd", 32'(rd_o), 4);
    tick();
    rdy = 1;
    #1;
    chk("st_stall3", 32'(stall), 0);
    chk("st_req3", 32'(req), 1);
    tick();
    chk("st_done_alu", alu_o, 32'h40);
    chk("st_done_err", 32'(mem_err), 0);

    clear_in();
    mr = 1; rw = 1; mtr = 1; rd = 7; alu = 32'h200; rdata = 32'hAAAA5555;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("to_stall%0d", i), 32'(stall), (i < 15) ? 1 : 0);
      chk($sformatf("to_req%0d", i), 32'(req), (i < 15) ? 1 : 0);
      tick();
    end
    chk("to_err", 32'(mem_err), 1);
    chk("to_rdata", rdata_o, 0);
    chk("to_rw", 32'(rw_o), 1);
    chk("to_alu", alu_o, 32'h200);
    clear_in();
    tick(); tick();
    chk("to_err_sticky", 32'(mem_err), 1);

    mr = 1; rw = 1; rd = 2; alu = 32'h300;
    tick();
    tick();
    reset = 1;
    clear_in();
    tick();
    chk("rw_req", 32'(req), 0);
    chk("rw_stall", 32'(stall), 0);
    chk("rw_rw", 32'(rw_o), 0);
    chk("rw_alu", alu_o, 0);
    chk("rw_rd", 32'(rd_o), 0);
    chk("rw_err", 32'(mem_err), 0);
    reset = 0;
    mr = 1; rw = 1; rd = 6; alu = 32'h300; rdata = 32'h5A;
    #1;
    chk("rw_ld_stall1", 32'(stall), 1);
    tick();
    rdy = 1;
    #1;
    chk("rw_ld_stall2", 32'(stall), 0);
    tick();
    chk("rw_ld_rdata", rdata_o, 32'h5A);
    chk("rw_ld_rw", 32'(rw_o), 1);
    chk("rw_ld_err", 32'(mem_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage plus MEM/WB register for the 5-stage RV32 core. Consumes the EX/MEM register outputs of the execution stage. Performs word loads and stores over a req/ready data-memory handshake and stalls the front of the pipe while memory is busy. Resolves branch, jal and jalr redirects, and registers results for write-back.

## Interface
Parameters:
- XLEN, 32, datapath width
- WAIT_MAX, 15, max dmem wait cycles before `mem_err` (width of wait counter = 4 bits)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in  in  1 each  EX/MEM control
- Zero_in, jal_in, jalr_in  in  1 each  branch/jump qualifiers
- Rd_in  in  5  destination register
- ALUresult_in, PCimm_in, ReadData2_in, PC_in  in  XLEN each  EX/MEM data
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  XLEN  equals ALUresult_in
- dmem_wdata  out  XLEN  equals ReadData2_in
- dmem_rdata  in  XLEN  load data, valid with dmem_ready
- dmem_ready  in  1  completes current request
- stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- flush  out  1  clears IF/ID and ID/EX controls
- PCSrc  out  1  take redirect target
- PCtarget  out  XLEN  redirect address
- mem_fwd_data  out  XLEN  forwarding value: ALUresult_in
- mem_err  out  1  sticky; dmem timeout
- Ctl_MemtoReg_out, Ctl_RegWrite_out  out  1 each  MEM/WB control
- Rd_out  out  5
- ReadData_out, ALUresult_out  out  XLEN each

## Operation
- mem_op = Ctl_MemRead_in | Ctl_MemWrite_in. If both are set, treat as write.
- FSM has two states, IDLE and WAIT.
  - IDLE: if mem_op, assert dmem_req. If dmem_ready in the same cycle, the access completes and FSM stays IDLE. Otherwise go to WAIT and clear the wait counter.
  - WAIT: hold dmem_req, dmem_we, addr and wdata stable. Counter increments each cycle.
    - On dmem_ready: complete and return to IDLE.
    - If counter reaches WAIT_MAX without ready: set mem_err, drop req, complete the instruction with ReadData_out = 0, return to IDLE.
- stall = mem_op & ~dmem_ready & ~timeout_now. Combinational, asserted in both IDLE and WAIT.
- Redirect (combinational, from EX/MEM contents):
  - taken = (Ctl_Branch_in & Zero_in) | jal_in | jalr_in
  - PCSrc = taken
  - flush = taken
  - PCtarget = jalr_in ? {ALUresult_in[XLEN-1:1],1'b0} : PCimm_in
  - Branch/jump instructions carry no mem_op, so redirect never coincides with stall.
- MEM/WB register, written every non-stalled cycle:
  - ALUresult_out = (jal_in|jalr_in) ? PC_in+4 : ALUresult_in
  - ReadData_out = dmem_rdata on load completion, else 0
  - Ctl_MemtoReg_out and Rd_out = inputs
  - Ctl_RegWrite_out = Ctl_RegWrite_in
- While stall is asserted, a bubble is inserted: Ctl_RegWrite_out = 0, Ctl_MemtoReg_out = 0, and the data fields hold.
- Arithmetic is XLEN-bit modulo; PC_in+4 wraps.

## Timing
- Reset: FSM=IDLE, counter=0, mem_err=0, and all MEM/WB outputs = 0. Combinational outputs follow their inputs.
- A zero-wait load or store: MEM/WB is valid one cycle after EX/MEM is valid, with no stall.
- N-wait access (N ≤ WAIT_MAX): stall high for N cycles, then MEM/WB is valid the cycle after ready.
- Reset during WAIT: FSM goes to IDLE the next edge, req drops, and no MEM/WB write occurs.
- dmem_ready outside a request is ignored.
- mem_err clears only on reset.

## Structure
- The shared package `core_pkg` holds XLEN, the FSM state enum {IDLE, WAIT}, and the PC increment constant 4.
- One sub-module is natural: `branch_resolve`, the combinational taken/PCtarget logic, reusable if resolution later moves to EX.

## Test plan
- Load, ALUresult_in=0x100, ready same cycle, rdata=0xDEADBEEF -> no stall; next cycle ReadData_out=0xDEADBEEF, RegWrite_out=1.
- Store, addr 0x40, wdata 0x1234, ready after 2 cycles -> stall high 2 cycles with dmem_we=1 and addr/wdata stable; RegWrite_out=0 during stall.
- beq with Zero_in=1, PCimm_in=0x80 -> PCSrc=1, flush=1, PCtarget=0x80. Same with Zero_in=0 -> PCSrc=0.
- jalr, ALUresult_in=0x203, PC_in=0x10 -> PCtarget=0x202; next cycle ALUresult_out=0x14.
- Load with ready never asserted, WAIT_MAX=15 -> stall for 15 cycles, then mem_err=1, ReadData_out=0, stall drops.
- Reset asserted in the 2nd WAIT cycle -> dmem_req=0 next cycle, FSM IDLE, all registered outputs 0.
